// File: rtl/risc8_fetch_queue.sv
// Instruction prefetch queue: streams memory words into a circular byte queue and presents a registered window, updated 1 cycle after fill/consume.
// Issue stalls while queued + in-flight words would exceed DEPTH; a redirect flushes the queue and discards stale responses.
module risc8_fetch_queue #(
   parameter int WORD_W      = 8,
   parameter int MEM_AW      = 16,
   parameter int FETCH_BYTES = 4,
   parameter int DEPTH       = 8,
   parameter logic [MEM_AW-1:0] RESET_PC = '0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   output logic                            mem_rd_en,
   output logic [MEM_AW-1:0]               mem_addr,
   input  logic                            mem_rd_valid,
   input  logic [WORD_W-1:0]               mem_rd_data,
   input  logic                            redirect,
   input  logic [MEM_AW-1:0]               redirect_pc,
   input  logic                            consume,
   input  logic [$clog2(FETCH_BYTES+1)-1:0] consume_len,
   output logic [FETCH_BYTES*WORD_W-1:0]   instr,
   output logic [MEM_AW-1:0]               instr_pc,
   output logic [$clog2(DEPTH+1)-1:0]      instr_avail,
   output logic                            consume_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WORD_W-1:0]             mem_q [DEPTH];
   logic [WORD_W-1:0]             mem_d [DEPTH];
   logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                 count_q, count_d, outst_q, outst_d, discard_q, discard_d;
   logic [MEM_AW-1:0]             fetch_pc_q, fetch_pc_d, instr_pc_q, instr_pc_d;
   logic [FETCH_BYTES*WORD_W-1:0] instr_q, instr_d;
   logic                          err_q, err_d;
   logic                          issue, legal, fill;

   always_comb begin
      mem_d      = mem_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      instr_pc_d = instr_pc_q;
      instr_d    = '0;
      err_d      = 1'b0;
      fill       = 1'b0;
      issue      = rst_n && !redirect &&
                   (((CW+1)'(count_q) + (CW+1)'(outst_q)) < (CW+1)'(DEPTH));
      legal      = consume && (consume_len != '0) && (CW'(consume_len) <= count_q);

      if (redirect) begin
         // Every request still in flight is now stale, except one answered this cycle.
         head_d     = tail_q;
         count_d    = '0;
         discard_d  = outst_q - CW'(mem_rd_valid);
         outst_d    = outst_q - CW'(mem_rd_valid);
         fetch_pc_d = redirect_pc;
         instr_pc_d = redirect_pc;
      end else begin
         fill = mem_rd_valid && (discard_q == '0);
         if (mem_rd_valid && (discard_q != '0))
            discard_d = discard_q - CW'(1);
         if (fill) begin
            mem_d[tail_q] = mem_rd_data;
            tail_d        = tail_q + PW'(1);
         end
         if (legal) begin
            head_d     = head_q + PW'(consume_len);
            instr_pc_d = instr_pc_q + MEM_AW'(consume_len);
         end
         count_d = count_q + CW'(fill) - (legal ? CW'(consume_len) : CW'(0));
         outst_d = outst_q + CW'(issue) - CW'(mem_rd_valid);
         err_d   = consume && !legal;
         if (issue)
            fetch_pc_d = fetch_pc_q + MEM_AW'(1);
      end

      // Window is built from next-state so a fill shows up one cycle after its strobe.
      for (int k = 0; k < FETCH_BYTES; k++) begin
         if (CW'(k) < count_d)
            instr_d[k*WORD_W +: WORD_W] = mem_d[head_d + PW'(k)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         fetch_pc_q <= RESET_PC;
         instr_pc_q <= RESET_PC;
         instr_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         fetch_pc_q <= fetch_pc_d;
         instr_pc_q <= instr_pc_d;
         instr_q    <= instr_d;
         err_q      <= err_d;
      end
   end

   assign mem_rd_en   = issue;
   assign mem_addr    = fetch_pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_avail = count_q;
   assign consume_err = err_q;
endmodule
